// File: rtl/axi_uart_tx_sched_pkg.sv
// Shared UART register map, AXI response codes and scheduler state encoding.
// Also used by the UART slave and by future UART clients.
package axi_uart_pkg;
  localparam logic [7:0] UART_ADDR_TXDATA    = 8'h00;
  localparam logic [7:0] UART_ADDR_STATUS    = 8'h04;
  localparam int         STATUS_TX_READY_BIT = 0;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B} tx_state_e;
endpackage

// File: rtl/axi_uart_tx_sched_if.sv
// AXI-Lite channel bundle between the TX scheduler (master) and the UART (slave).
interface axi_uart_tx_sched_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid, awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [3:0]            wstrb;
  logic                  wvalid, wready;
  logic [1:0]            bresp;
  logic                  bvalid, bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid, arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid, rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick; search starts at last_grant+1 and wraps.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  int j;

  // Walk from lowest to highest priority so the highest-priority hit wins last.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = 0;
    if (en) begin
      for (int k = NREQ; k >= 1; k--) begin
        j = int'(last_grant) + k;
        if (j >= NREQ) j = j - NREQ;
        if (req[j]) begin
          gnt    = '0;
          gnt[j] = 1'b1;
          idx    = IW'(j);
        end
      end
    end
  end
endmodule

// File: rtl/axi_uart_tx_sched.sv
// Shares one AXI-Lite UART among NREQ byte clients: accept, poll STATUS, write TXDATA.
// All outputs are registered; req_ready is precomputed the cycle before IDLE is entered.
module axi_uart_tx_sched
  import axi_uart_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_POLLS  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*8-1:0]        req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     drop_err,
  output logic                     wr_err,
  axi_uart_tx_sched_if.master      m_axi
);
  localparam int IW = $clog2(NREQ);
  localparam int PW = $clog2(MAX_POLLS + 1);

  tx_state_e             state_q, state_d;
  logic                  ar_valid_q, ar_valid_d, r_ready_q, r_ready_d;
  logic                  aw_valid_q, aw_valid_d, w_valid_q, w_valid_d, b_ready_q, b_ready_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d, aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [3:0]            w_strb_q, w_strb_d;
  logic [7:0]            byte_q, byte_d;
  logic [PW-1:0]         poll_q, poll_d;
  logic [IW-1:0]         last_q, last_d, grant_id_q, grant_id_d, pend_idx_q, arb_idx;
  logic [NREQ-1:0]       req_ready_q, arb_gnt;
  logic                  busy_q, drop_q, drop_d, wr_err_q, wr_err_d, accept, arb_en;
  logic                  unused_rdata;

  assign unused_rdata = ^m_axi.rdata;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(req_valid), .en(arb_en), .last_grant(last_q), .gnt(arb_gnt), .idx(arb_idx)
  );

  always_comb begin
    state_d    = state_q;
    ar_valid_d = ar_valid_q;  r_ready_d = r_ready_q;
    aw_valid_d = aw_valid_q;  w_valid_d = w_valid_q;  b_ready_d = b_ready_q;
    ar_addr_d  = ar_addr_q;   aw_addr_d = aw_addr_q;
    w_data_d   = w_data_q;    w_strb_d  = w_strb_q;
    byte_d     = byte_q;      poll_d    = poll_q;
    last_d     = last_q;      grant_id_d = grant_id_q;
    drop_d     = 1'b0;        wr_err_d  = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      S_IDLE: if (|(req_valid & req_ready_q)) begin
        accept     = 1'b1;
        state_d    = S_AR;
        byte_d     = req_data[{pend_idx_q, 3'b000} +: 8];
        grant_id_d = pend_idx_q;
        last_d     = pend_idx_q;
        poll_d     = '0;
        ar_valid_d = 1'b1;
        ar_addr_d  = ADDR_WIDTH'(UART_ADDR_STATUS);
      end
      S_AR: if (m_axi.arready) begin
        ar_valid_d = 1'b0;
        r_ready_d  = 1'b1;
        state_d    = S_R;
      end
      S_R: if (m_axi.rvalid) begin
        r_ready_d = 1'b0;
        if (m_axi.rresp == AXI_RESP_OKAY && m_axi.rdata[STATUS_TX_READY_BIT]) begin
          state_d    = S_WR;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          aw_addr_d  = ADDR_WIDTH'(UART_ADDR_TXDATA);
          w_data_d   = DATA_WIDTH'(byte_q);
          w_strb_d   = 4'b0001;
        end else if (poll_q == PW'(MAX_POLLS - 1)) begin
          drop_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          poll_d     = poll_q + PW'(1);
          ar_valid_d = 1'b1;
          state_d    = S_AR;
        end
      end
      S_WR: begin
        // AW and W retire independently; leave once both valids have dropped.
        aw_valid_d = aw_valid_q & ~m_axi.awready;
        w_valid_d  = w_valid_q  & ~m_axi.wready;
        if (!aw_valid_d && !w_valid_d) begin
          b_ready_d = 1'b1;
          state_d   = S_B;
        end
      end
      S_B: if (m_axi.bvalid) begin
        b_ready_d = 1'b0;
        wr_err_d  = (m_axi.bresp != AXI_RESP_OKAY);
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    arb_en = (state_d == S_IDLE) && !accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ar_valid_q  <= 1'b0;  r_ready_q <= 1'b0;
      aw_valid_q  <= 1'b0;  w_valid_q <= 1'b0;  b_ready_q <= 1'b0;
      ar_addr_q   <= '0;    aw_addr_q <= '0;
      w_data_q    <= '0;    w_strb_q  <= '0;
      byte_q      <= '0;    poll_q    <= '0;
      last_q      <= IW'(NREQ - 1);
      grant_id_q  <= '0;    pend_idx_q <= '0;
      req_ready_q <= '0;    busy_q    <= 1'b0;
      drop_q      <= 1'b0;  wr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ar_valid_q  <= ar_valid_d;  r_ready_q <= r_ready_d;
      aw_valid_q  <= aw_valid_d;  w_valid_q <= w_valid_d;  b_ready_q <= b_ready_d;
      ar_addr_q   <= ar_addr_d;   aw_addr_q <= aw_addr_d;
      w_data_q    <= w_data_d;    w_strb_q  <= w_strb_d;
      byte_q      <= byte_d;      poll_q    <= poll_d;
      last_q      <= last_d;
      grant_id_q  <= grant_id_d;  pend_idx_q <= arb_idx;
      req_ready_q <= arb_gnt;     busy_q    <= (state_d != S_IDLE);
      drop_q      <= drop_d;      wr_err_q  <= wr_err_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign busy          = busy_q;
  assign grant_id      = grant_id_q;
  assign drop_err      = drop_q;
  assign wr_err        = wr_err_q;
  assign m_axi.arvalid = ar_valid_q;
  assign m_axi.araddr  = ar_addr_q;
  assign m_axi.rready  = r_ready_q;
  assign m_axi.awvalid = aw_valid_q;
  assign m_axi.awaddr  = aw_addr_q;
  assign m_axi.wvalid  = w_valid_q;
  assign m_axi.wdata   = w_data_q;
  assign m_axi.wstrb   = w_strb_q;
  assign m_axi.bready  = b_ready_q;
endmodule

// File: doc/axi_uart_tx_sched.md
# axi_uart_tx_sched

Round-robin scheduler that shares one AXI-Lite UART transmitter among NREQ byte-producing clients. Acts as the single AXI-Lite master in front of the UART slave: it accepts one byte from a client, polls the UART STATUS register until tx_ready is set, writes the byte to TXDATA, then returns to arbitration. A bounded poll count prevents a stuck UART from hanging the system.

## Interface
Parameters:
- NREQ, 4: number of requesting clients (2..8).
- ADDR_WIDTH, 4: AXI-Lite address width.
- DATA_WIDTH, 32: AXI-Lite data width.
- MAX_POLLS, 16: consecutive not-ready STATUS reads before a byte is dropped (>=1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-client byte valid.
- req_data  in  8*NREQ  per-client byte; client i uses bits [8i+7:8i].
- req_ready  out  NREQ  one-hot accept pulse; byte i transfers when req_valid[i] && req_ready[i].
- busy  out  1  high from accept until return to IDLE.
- grant_id  out  $clog2(NREQ)  index of the client currently served; holds the last value when idle.
- drop_err  out  1  one-cycle pulse when a byte is dropped after MAX_POLLS.
- wr_err  out  1  one-cycle pulse on a BRESP != OKAY.
- M_AXI_AWADDR/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI-Lite master channels, widths per parameters, WSTRB 4 bits.

## Operation
- Register map used: TXDATA = 0x0, STATUS = 0x4, with STATUS bit0 = tx_ready.
- FSM states:
  - IDLE: if any req_valid is set, pick a winner by round-robin, pulse its req_ready, capture its byte, set grant_id, clear the poll counter, go to AR.
  - AR: ARVALID=1, ARADDR=0x4; on ARREADY go to R.
  - R: RREADY=1; on RVALID:
    - if RRESP==OKAY and RDATA[0]==1, go to WR;
    - otherwise increment the poll counter; if the counter reaches MAX_POLLS, pulse drop_err and go to IDLE; else go to AR.
  - WR: AWVALID=1, AWADDR=0x0, WVALID=1, WDATA={24'b0, byte}, WSTRB=4'b0001.
    - Each valid deasserts independently on its own ready.
    - Go to B once both handshakes have completed, in the same cycle or in different cycles.
  - B: BREADY=1; on BVALID pulse wr_err if BRESP != 0, go to IDLE.
- Round-robin: search starts at last_grant+1 mod NREQ. last_grant resets to NREQ-1, so client 0 has first priority. last_grant updates on every accept.
- Only one byte is outstanding at a time. req_ready stays 0 outside IDLE.
- Reset mid-transaction aborts immediately: FSM returns to IDLE, all valids drop, the captured byte is lost.

## Timing
- Reset values: all M_AXI_*VALID and *READY = 0, AWADDR/ARADDR/WDATA = 0, WSTRB = 0, req_ready = 0, busy = 0, grant_id = 0, drop_err = 0, wr_err = 0.
- Accept cycle T: req_ready pulses, busy rises at T+1, ARVALID is asserted at T+1.
- Minimum service time with zero-wait slave (ready/valid same cycle as request): 4 cycles from accept to IDLE (AR, R, WR, B). The next accept can occur on the following cycle.
- All outputs are registered.
- Valid signals never drop before their handshake completes.
- ADDR/DATA are stable while the corresponding valid is high.

## Structure
- Package axi_uart_pkg:
  - UART_ADDR_TXDATA, UART_ADDR_STATUS, STATUS_TX_READY_BIT;
  - AXI_RESP_OKAY/SLVERR;
  - FSM state encoding;
  - shared with the UART slave and future UART clients.
- Sub-module rr_arbiter:
  - inputs: NREQ request vector, enable, last_grant;
  - outputs: one-hot grant and encoded index;
  - combinational search, with the last_grant register held in the parent.

## Test plan
- Single client: client 0 sends 0xA5, slave STATUS=1 -> one AR to 0x4, one AW/W to 0x0 with WDATA=0x000000A5, WSTRB=0x1, req_ready[0] pulses once, busy returns low.
- Contention: clients 0, 1, 2 hold valid continuously with 0x11/0x22/0x33 -> TXDATA writes in order 0x11, 0x22, 0x33, 0x11…, with no client served twice in a row.
- Slow UART: STATUS returns 0 three times then 1 -> 4 reads then 1 write, no drop_err.
- Stuck UART: STATUS always 0, MAX_POLLS=16 -> exactly 16 reads, one drop_err pulse, no AW/W issued, FSM back in IDLE.
- Skewed handshakes: AWREADY delayed 3 cycles after WREADY -> WVALID drops after WREADY, AWVALID held until AWREADY, then exactly one B; BRESP=SLVERR yields one wr_err pulse.
- Reset during the R state -> all valids 0 on the next edge, busy=0, and the next request goes to client 0.
